// File: rtl/sort_sbu_scan_ctrl_pkg.sv
// Shared constants, types and helpers for the SBU occupancy-bitmap scan controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
`ifndef SORT_FUC_MAX_NUM
`define SORT_FUC_MAX_NUM 1024
`endif
`ifndef SORT_PERF_SBU_TILE_NUM
`define SORT_PERF_SBU_TILE_NUM 4
`endif

package sort_sbu_scan_ctrl_pkg;

  localparam int SORT_FUC_MAX_NUM       = `SORT_FUC_MAX_NUM;
  localparam int SORT_PERF_SBU_TILE_NUM = `SORT_PERF_SBU_TILE_NUM;
  localparam int SORT_PERF_SBU_NUM      = SORT_FUC_MAX_NUM / SORT_PERF_SBU_TILE_NUM;
  localparam int SORT_FUC_SBU_ADDR_W    = $clog2(SORT_PERF_SBU_NUM);
  localparam int SCAN_FIFO_DEPTH        = 4;
  localparam int SCAN_FIFO_CNT_W        = $clog2(SCAN_FIFO_DEPTH) + 1;

  typedef logic [SORT_FUC_SBU_ADDR_W-1:0] sbu_addr_t;

  localparam sbu_addr_t SBU_ADDR_LAST = sbu_addr_t'(SORT_PERF_SBU_NUM - 1);

  // Scan FSM encoding
  localparam logic [1:0] SCAN_IDLE  = 2'd0;
  localparam logic [1:0] SCAN_RUN   = 2'd1;
  localparam logic [1:0] SCAN_DRAIN = 2'd2;
  localparam logic [1:0] SCAN_DONE  = 2'd3;

  // Next pointer in scan order: dir=0 ascending, dir=1 descending.
  function automatic sbu_addr_t scan_step(sbu_addr_t p, logic d);
    return d ? (p - sbu_addr_t'(1)) : (p + sbu_addr_t'(1));
  endfunction

endpackage

// File: rtl/sort_sbu_scan_ctrl_if.sv
// SBU read port plus the hit stream towards the PRU, bundled for the scan controller.
// Latency: n/a (wires only); read data is expected in the same cycle as the strobe.
// Backpressure: hit stream is valid/ready; SBU read port has none.
// master = scan controller, slave = SBU/PRU side.
interface sort_sbu_scan_ctrl_if;
  import sort_sbu_scan_ctrl_pkg::*;

  logic      ctrl2sbu_rd_vld_o;
  sbu_addr_t ctrl2sbu_rd_addr_o;
  logic      sbu2ctrl_rd_vld_i;
  sbu_addr_t sbu2ctrl_rd_addr_i;
  logic      sbu2ctrl_rd_data_i;
  logic      hit_vld_o;
  sbu_addr_t hit_addr_o;
  logic      hit_rdy_i;

  modport master (
    output ctrl2sbu_rd_vld_o, ctrl2sbu_rd_addr_o, hit_vld_o, hit_addr_o,
    input  sbu2ctrl_rd_vld_i, sbu2ctrl_rd_addr_i, sbu2ctrl_rd_data_i, hit_rdy_i
  );

  modport slave (
    input  ctrl2sbu_rd_vld_o, ctrl2sbu_rd_addr_o, hit_vld_o, hit_addr_o,
    output sbu2ctrl_rd_vld_i, sbu2ctrl_rd_addr_i, sbu2ctrl_rd_data_i, hit_rdy_i
  );

endinterface

// File: rtl/sort_sbu_scan_ctrl_fifo.sv
// Small registered FIFO holding hit addresses (module sort_sbu_scan_fifo).
// Latency: push in cycle t is visible at head_data/!empty in cycle t+1.
// Backpressure: push ignored when full, pop ignored when empty; flush empties in one cycle.
// Ports: push/push_data write side, pop read side, flush, empty/full/cnt status, head_data.
module sort_sbu_scan_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] cnt,
  output logic [WIDTH-1:0] head_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty     = (cnt == '0);
  assign full      = (cnt == CNT_W'(DEPTH));
  assign push_ok   = push && !full;
  assign pop_ok    = pop && !empty;
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push_ok && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/sort_sbu_scan_ctrl.sv
// Walks the SBU occupancy bitmap with one read-and-clear per cycle and streams set addresses.
// Latency: a hit read in cycle t is offered on hit_vld_o in cycle t+1.
// Backpressure: reads stall (pointer held) while the hit FIFO is full; hit stream is valid/ready.
// Ports: clk/rst; scan_start_i/scan_dir_i/scan_abort_i control; bus (master) carries the SBU
// read port and the hit stream; scan_busy_o/scan_done_o/hit_cnt_o status.
module sort_sbu_scan_ctrl
  import sort_sbu_scan_ctrl_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         scan_start_i,
  input  logic                         scan_dir_i,
  input  logic                         scan_abort_i,
  sort_sbu_scan_ctrl_if.master         bus,
  output logic                         scan_busy_o,
  output logic                         scan_done_o,
  output logic [SORT_FUC_SBU_ADDR_W:0] hit_cnt_o
);

  logic [1:0]                   state;
  sbu_addr_t                    ptr;
  logic                         dir;
  logic [SORT_FUC_SBU_ADDR_W:0] hit_cnt;

  logic                       fifo_empty;
  logic                       fifo_full;
  logic [SCAN_FIFO_CNT_W-1:0] fifo_cnt;
  sbu_addr_t                  fifo_head;

  logic abort;
  logic room;
  logic issue;
  logic last;
  logic hit_push;
  logic hit_pop;

  assign abort = scan_abort_i && (state != SCAN_IDLE);
  // Room is judged on registered occupancy only; a pop this cycle does not free a slot early.
  assign room  = (fifo_cnt < SCAN_FIFO_CNT_W'(SCAN_FIFO_DEPTH));
  assign issue = (state == SCAN_RUN) && room && !scan_abort_i;
  // The SBU answers in the same cycle, so the echo is only trusted while we are issuing.
  assign hit_push = issue && bus.sbu2ctrl_rd_vld_i && bus.sbu2ctrl_rd_data_i && !fifo_full;
  assign hit_pop  = !fifo_empty && bus.hit_rdy_i;
  assign last     = dir ? (ptr == '0) : (ptr == SBU_ADDR_LAST);

  sort_sbu_scan_fifo #(
    .WIDTH (SORT_FUC_SBU_ADDR_W),
    .DEPTH (SCAN_FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (hit_push),
    .push_data (bus.sbu2ctrl_rd_addr_i),
    .pop       (hit_pop),
    .flush     (abort),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .cnt       (fifo_cnt),
    .head_data (fifo_head)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SCAN_IDLE;
      ptr   <= '0;
      dir   <= 1'b0;
    end else begin
      case (state)
        SCAN_IDLE: begin
          if (scan_start_i) begin
            dir   <= scan_dir_i;
            ptr   <= scan_dir_i ? SBU_ADDR_LAST : '0;
            state <= SCAN_RUN;
          end
        end
        SCAN_RUN: begin
          if (abort) begin
            state <= SCAN_IDLE;
          end else if (issue) begin
            // No wrap: the final address hands over to the drain phase.
            if (last) state <= SCAN_DRAIN;
            else      ptr   <= scan_step(ptr, dir);
          end
        end
        SCAN_DRAIN: begin
          if (abort)           state <= SCAN_IDLE;
          else if (fifo_empty) state <= SCAN_DONE;
        end
        default: state <= SCAN_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt <= '0;
    end else if ((state == SCAN_IDLE) && scan_start_i) begin
      hit_cnt <= '0;
    end else if (hit_push) begin
      hit_cnt <= hit_cnt + (SORT_FUC_SBU_ADDR_W + 1)'(1);
    end
  end

  assign bus.ctrl2sbu_rd_vld_o  = issue;
  assign bus.ctrl2sbu_rd_addr_o = ptr;
  assign bus.hit_vld_o          = !fifo_empty;
  // Head is masked when empty so a flushed or drained FIFO never shows a stale address.
  assign bus.hit_addr_o         = fifo_empty ? '0 : fifo_head;
  assign scan_busy_o            = (state != SCAN_IDLE);
  assign scan_done_o            = (state == SCAN_DONE) && !scan_abort_i;
  assign hit_cnt_o              = hit_cnt;

endmodule

// File: tb/tb_sort_sbu_scan_ctrl.sv
// Bench for sort_sbu_scan_ctrl: behavioural SBU bitmap, directed scenarios plus random scans.
// Latency: n/a.
// Backpressure: hit_rdy driven directed or random.
module tb_sort_sbu_scan_ctrl;
  import sort_sbu_scan_ctrl_pkg::*;

  localparam int N = SORT_PERF_SBU_NUM;

  logic clk = 1'b0;
  logic rst;
  logic start, dir_in, abort, hit_rdy;
  logic busy, done;
  logic [SORT_FUC_SBU_ADDR_W:0] hit_cnt;

  logic         load_en;
  logic [N-1:0] load_val;
  logic [N-1:0] sbu;
  logic         agu0_we, agu1_we;
  sbu_addr_t    agu0_addr, agu1_addr;

  always #5 clk = ~clk;

  sort_sbu_scan_ctrl_if bus();

  assign bus.sbu2ctrl_rd_vld_i  = bus.ctrl2sbu_rd_vld_o;
  assign bus.sbu2ctrl_rd_addr_i = bus.ctrl2sbu_rd_addr_o;
  assign bus.sbu2ctrl_rd_data_i = sbu[bus.ctrl2sbu_rd_addr_o];
  assign bus.hit_rdy_i          = hit_rdy;

  sort_sbu_scan_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .scan_start_i (start),
    .scan_dir_i   (dir_in),
    .scan_abort_i (abort),
    .bus          (bus),
    .scan_busy_o  (busy),
    .scan_done_o  (done),
    .hit_cnt_o    (hit_cnt)
  );

  // SBU bitmap: read clears, AGU write sets; a write wins over a clear at the same address.
  always @(posedge clk) begin
    if (load_en) begin
      sbu <= load_val;
    end else begin
      if (bus.ctrl2sbu_rd_vld_o) sbu[bus.ctrl2sbu_rd_addr_o] <= 1'b0;
      if (agu0_we) sbu[agu0_addr] <= 1'b1;
      if (agu1_we) sbu[agu1_addr] <= 1'b1;
    end
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model state: expected hit order, occupancy, expected next read address.
  int exp_q[$];
  int exp_n;
  int occ, reads, exp_rd, done_cnt, done_total;
  bit mon_en = 0, scan_on = 0, mon_dir = 0;

  always @(negedge clk) begin
    bit push, pop;
    if (done) done_total++;
    if (mon_en && !rst) begin
      push = bus.ctrl2sbu_rd_vld_o && sbu[bus.ctrl2sbu_rd_addr_o];
      pop  = bus.hit_vld_o && hit_rdy;
      chk("hit_vld", {31'd0, bus.hit_vld_o}, {31'd0, occ > 0});
      if (scan_on && reads < N && occ < SCAN_FIFO_DEPTH)
        chk("rd_issue", {31'd0, bus.ctrl2sbu_rd_vld_o}, 1);
      if (bus.ctrl2sbu_rd_vld_o) begin
        chk("issue_room", {31'd0, occ < SCAN_FIFO_DEPTH}, 1);
        chk("rd_addr", 32'(bus.ctrl2sbu_rd_addr_o), exp_rd);
        exp_rd = mon_dir ? exp_rd - 1 : exp_rd + 1;
        reads++;
      end
      if (pop) begin
        chk("hit_pending", {31'd0, exp_q.size() > 0}, 1);
        if (exp_q.size() > 0) chk("hit_addr", 32'(bus.hit_addr_o), exp_q.pop_front());
      end
      if (done) done_cnt++;
      occ = occ + int'(push) - int'(pop);
      if (start && !busy) scan_on = 1;
    end
  end

  task automatic preload(input logic [N-1:0] v);
    load_en = 1'b1; load_val = v;
    @(posedge clk); #1;
    load_en = 1'b0;
  endtask

  task automatic build_exp(input bit d);
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      int a;
      a = d ? N - 1 - i : i;
      if (sbu[a]) exp_q.push_back(a);
    end
    exp_n = exp_q.size();
  endtask

  task automatic run_scan(input bit d, input bit rnd_rdy, input int hold, input bit agu_mode);
    int cyc;
    occ = 0; reads = 0; exp_rd = d ? N - 1 : 0; mon_dir = d;
    done_cnt = 0; scan_on = 0; mon_en = 1;
    start = 1'b1; dir_in = d; hit_rdy = (hold > 0) ? 1'b0 : 1'b1;
    @(posedge clk); #1;
    start = 1'b0; dir_in = $urandom_range(0, 1);
    cyc = 0;
    while (done_cnt == 0 && cyc < 5000) begin
      if (hold > 0 && cyc == hold) begin
        chk("stall_reads", reads, 4);
        chk("stall_ptr", 32'(bus.ctrl2sbu_rd_addr_o), d ? N - 5 : 4);
      end
      hit_rdy = (cyc < hold) ? 1'b0 : (rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
      agu0_we = 1'b0; agu1_we = 1'b0;
      if (agu_mode && bus.ctrl2sbu_rd_vld_o) begin
        if (bus.ctrl2sbu_rd_addr_o == 8'd40) begin
          agu0_we = 1'b1; agu0_addr = 8'd10;
          agu1_we = 1'b1; agu1_addr = 8'd200;
        end
        if (bus.ctrl2sbu_rd_addr_o == 8'd50) begin
          agu0_we = 1'b1; agu0_addr = 8'd50;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    agu0_we = 1'b0; agu1_we = 1'b0; hit_rdy = 1'b1;
    chk("scan_timeout", {31'd0, cyc < 5000}, 1);
    repeat (3) begin @(posedge clk); #1; end
    mon_en = 0; scan_on = 0;
    chk("done_once", done_cnt, 1);
    chk("q_empty", exp_q.size(), 0);
    chk("hit_cnt", 32'(hit_cnt), exp_n);
    chk("busy_end", {31'd0, busy}, 0);
    chk("hit_vld_end", {31'd0, bus.hit_vld_o}, 0);
  endtask

  initial begin
    int c, dt;
    logic [N-1:0] v;
    start = 0; dir_in = 0; abort = 0; hit_rdy = 1; load_en = 0; load_val = '0;
    agu0_we = 0; agu1_we = 0; agu0_addr = '0; agu1_addr = '0;
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_rd_vld", {31'd0, bus.ctrl2sbu_rd_vld_o}, 0);
    chk("rst_rd_addr", 32'(bus.ctrl2sbu_rd_addr_o), 0);
    chk("rst_hit_vld", {31'd0, bus.hit_vld_o}, 0);
    chk("rst_hit_addr", 32'(bus.hit_addr_o), 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_hit_cnt", 32'(hit_cnt), 0);

    // Sparse bitmap, ascending then descending.
    for (int d = 0; d < 2; d++) begin
      v = '0; v[3] = 1'b1; v[17] = 1'b1; v[255] = 1'b1;
      preload(v);
      build_exp(d[0]);
      run_scan(d[0], 1'b0, 0, 1'b0);
      chk("bitmap_zero", {31'd0, sbu == '0}, 1);
    end

    // Full bitmap with 20 cycles of downstream backpressure.
    preload('1);
    build_exp(1'b0);
    run_scan(1'b0, 1'b0, 20, 1'b0);
    chk("full_bitmap_zero", {31'd0, sbu == '0}, 1);

    // Abort with ptr=100 and two hits queued.
    v = '0; v[98] = 1'b1; v[99] = 1'b1; v[100] = 1'b1; v[150] = 1'b1;
    preload(v);
    hit_rdy = 1'b0; start = 1'b1; dir_in = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    c = 0;
    while (!(bus.ctrl2sbu_rd_vld_o && bus.ctrl2sbu_rd_addr_o == 8'd99) && c < 1000) begin
      @(negedge clk); c++;
    end
    chk("abort_reach", {31'd0, c < 1000}, 1);
    dt = done_total;
    @(posedge clk); #1;
    abort = 1'b1;
    @(negedge clk);
    chk("abort_no_rd", {31'd0, bus.ctrl2sbu_rd_vld_o}, 0);
    chk("abort_fifo_had", {31'd0, bus.hit_vld_o}, 1);
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_hit_vld", {31'd0, bus.hit_vld_o}, 0);
    chk("abort_hit_addr", 32'(bus.hit_addr_o), 0);
    chk("abort_no_done", done_total, dt);
    chk("abort_bit100", {31'd0, sbu[100]}, 1);
    chk("abort_bit99", {31'd0, sbu[99]}, 0);
    hit_rdy = 1'b1;
    build_exp(1'b0);
    run_scan(1'b0, 1'b0, 0, 1'b0);

    // Concurrent AGU writes: same-address, behind and ahead of the pointer.
    preload('0);
    exp_q.delete(); exp_q.push_back(200); exp_n = 1;
    run_scan(1'b0, 1'b0, 0, 1'b1);
    chk("agu_bit50", {31'd0, sbu[50]}, 1);
    chk("agu_bit10", {31'd0, sbu[10]}, 1);
    chk("agu_bit200", {31'd0, sbu[200]}, 0);

    // Random bitmaps, directions and ready patterns.
    for (int r = 0; r < 4; r++) begin
      int dens;
      bit d;
      dens = $urandom_range(1, 8);
      for (int i = 0; i < N; i++) v[i] = ($urandom_range(0, dens) == 0);
      d = 1'($urandom_range(0, 1));
      preload(v);
      build_exp(d);
      run_scan(d, 1'b1, 0, 1'b0);
      chk("rand_bitmap_zero", {31'd0, sbu == '0}, 1);
    end

    // Asynchronous reset in the middle of a stalled scan.
    preload('1);
    hit_rdy = 1'b0; start = 1'b1; dir_in = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 0);
    chk("mid_rst_done", {31'd0, done}, 0);
    chk("mid_rst_rd_vld", {31'd0, bus.ctrl2sbu_rd_vld_o}, 0);
    chk("mid_rst_rd_addr", 32'(bus.ctrl2sbu_rd_addr_o), 0);
    chk("mid_rst_hit_vld", {31'd0, bus.hit_vld_o}, 0);
    chk("mid_rst_hit_addr", 32'(bus.hit_addr_o), 0);
    chk("mid_rst_hit_cnt", 32'(hit_cnt), 0);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_busy", {31'd0, busy}, 0);
    chk("post_rst_hit_vld", {31'd0, bus.hit_vld_o}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
